// File: rtl/exec_stage_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage_muldiv_if
// Brief    : ID/EX-side operand/control bundle and EX result bundle.
// Revision : 1.0
// ============================================================================
interface exec_stage_muldiv_if #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
);
    localparam int c_sel_w = $clog2(NUM_FWD + 1);

    logic                      i_valid;
    logic                      i_flush;
    logic [XLEN-1:0]           i_rd1;
    logic [XLEN-1:0]           i_rd2;
    logic [XLEN-1:0]           i_immext;
    logic [XLEN-1:0]           i_pc;
    logic [NUM_FWD*XLEN-1:0]   i_fwd_data;
    logic [c_sel_w-1:0]        i_fwd_sel_a;
    logic [c_sel_w-1:0]        i_fwd_sel_b;
    logic [3:0]                i_alu_control;
    logic                      i_alu_src_a;
    logic                      i_alu_src_b;
    logic                      i_pc_adder_src;
    logic                      i_md_en;
    logic [2:0]                i_md_op;
    logic [XLEN-1:0]           o_result;
    logic                      o_result_valid;
    logic [XLEN-1:0]           o_memory_data;
    logic [3:0]                o_alu_flags;
    logic [XLEN-1:0]           o_pc_adder_result;
    logic                      o_stall;

    modport master (
        output i_valid, i_flush, i_rd1, i_rd2, i_immext, i_pc, i_fwd_data,
               i_fwd_sel_a, i_fwd_sel_b, i_alu_control, i_alu_src_a, i_alu_src_b,
               i_pc_adder_src, i_md_en, i_md_op,
        input  o_result, o_result_valid, o_memory_data, o_alu_flags,
               o_pc_adder_result, o_stall
    );

    modport slave (
        input  i_valid, i_flush, i_rd1, i_rd2, i_immext, i_pc, i_fwd_data,
               i_fwd_sel_a, i_fwd_sel_b, i_alu_control, i_alu_src_a, i_alu_src_b,
               i_pc_adder_src, i_md_en, i_md_op,
        output o_result, o_result_valid, o_memory_data, o_alu_flags,
               o_pc_adder_result, o_stall
    );
endinterface
`default_nettype wire

// File: rtl/exec_stage_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exec_stage_muldiv
// Brief    : Execute stage: forwarding, ALU, target adder, multi-cycle RV32M unit.
// Revision : 1.0
// ============================================================================
module exec_stage_muldiv #(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    exec_stage_muldiv_if.slave bus
);
    localparam int c_sel_w    = $clog2(NUM_FWD + 1);
    localparam int c_sh_w     = $clog2(XLEN);
    localparam int c_cnt_max  = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam int c_mul_last = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_and  = 4'd2;
    localparam logic [3:0] c_alu_or   = 4'd3;
    localparam logic [3:0] c_alu_xor  = 4'd4;
    localparam logic [3:0] c_alu_slt  = 4'd5;
    localparam logic [3:0] c_alu_sltu = 4'd6;
    localparam logic [3:0] c_alu_sll  = 4'd7;
    localparam logic [3:0] c_alu_srl  = 4'd8;
    localparam logic [3:0] c_alu_sra  = 4'd9;
    localparam logic [3:0] c_alu_lui  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [XLEN-1:0]     r_a, r_b, r_quo, r_rem, r_dvs;
    logic [2:0]          r_op;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [XLEN-1:0]     w_fwd_a, w_fwd_b, w_alu_a, w_alu_b, w_alu_result;
    logic [XLEN:0]       w_add, w_sub;
    logic                w_c, w_v, w_start, w_stall, w_md_valid;
    logic [c_sh_w-1:0]   w_shamt;

    // Forwarding: out-of-range selects fall back to the register file
    always_comb begin
        w_fwd_a = bus.i_rd1;
        w_fwd_b = bus.i_rd2;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (bus.i_fwd_sel_a == c_sel_w'(k)) w_fwd_a = bus.i_fwd_data[(k-1)*XLEN +: XLEN];
            if (bus.i_fwd_sel_b == c_sel_w'(k)) w_fwd_b = bus.i_fwd_data[(k-1)*XLEN +: XLEN];
        end
    end

    assign w_alu_a = bus.i_alu_src_a ? bus.i_pc     : w_fwd_a;
    assign w_alu_b = bus.i_alu_src_b ? bus.i_immext : w_fwd_b;
    assign w_add   = {1'b0, w_alu_a} + {1'b0, w_alu_b};
    // Carry on subtract means "no borrow"
    assign w_sub   = {1'b0, w_alu_a} + {1'b0, ~w_alu_b} + {{XLEN{1'b0}}, 1'b1};
    assign w_shamt = w_alu_b[c_sh_w-1:0];

    always_comb begin
        w_alu_result = w_add[XLEN-1:0];
        w_c          = 1'b0;
        w_v          = 1'b0;
        case (bus.i_alu_control)
            c_alu_add: begin
                w_c = w_add[XLEN];
                w_v = (w_alu_a[XLEN-1] == w_alu_b[XLEN-1]) && (w_add[XLEN-1] != w_alu_a[XLEN-1]);
            end
            c_alu_sub: begin
                w_alu_result = w_sub[XLEN-1:0];
                w_c = w_sub[XLEN];
                w_v = (w_alu_a[XLEN-1] != w_alu_b[XLEN-1]) && (w_sub[XLEN-1] != w_alu_a[XLEN-1]);
            end
            c_alu_and:  w_alu_result = w_alu_a & w_alu_b;
            c_alu_or:   w_alu_result = w_alu_a | w_alu_b;
            c_alu_xor:  w_alu_result = w_alu_a ^ w_alu_b;
            c_alu_slt:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
            c_alu_sltu: w_alu_result = {{(XLEN-1){1'b0}}, (w_alu_a < w_alu_b)};
            c_alu_sll:  w_alu_result = w_alu_a << w_shamt;
            c_alu_srl:  w_alu_result = w_alu_a >> w_shamt;
            c_alu_sra:  w_alu_result = $signed(w_alu_a) >>> w_shamt;
            c_alu_lui:  w_alu_result = w_alu_b;
            default:    w_alu_result = w_add[XLEN-1:0];
        endcase
    end

    // Multiplier: operand sign extension chosen by funct3 (MUL/MULH/MULHSU/MULHU)
    logic              w_mul_sa, w_mul_sb;
    logic [2*XLEN-1:0] w_mul_a_ext, w_mul_b_ext, w_prod;
    logic [XLEN-1:0]   w_mul_result;

    assign w_mul_sa     = (r_op[1:0] != 2'b11);
    assign w_mul_sb     = (r_op[1:0] == 2'b01);
    assign w_mul_a_ext  = {{XLEN{w_mul_sa & r_a[XLEN-1]}}, r_a};
    assign w_mul_b_ext  = {{XLEN{w_mul_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod       = w_mul_a_ext * w_mul_b_ext;
    assign w_mul_result = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // Divider: restoring, one quotient bit per cycle on magnitudes
    logic            w_div_signed_in, w_div_signed, w_div_zero;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix, w_div_result, w_md_result;
    logic [XLEN:0]   w_div_shift, w_div_trial;

    assign w_div_signed_in = ~bus.i_md_op[0];
    assign w_a_mag      = (w_div_signed_in & w_fwd_a[XLEN-1]) ? -w_fwd_a : w_fwd_a;
    assign w_b_mag      = (w_div_signed_in & w_fwd_b[XLEN-1]) ? -w_fwd_b : w_fwd_b;
    assign w_div_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_div_trial  = w_div_shift - {1'b0, r_dvs};
    assign w_div_signed = ~r_op[0];
    assign w_div_zero   = (r_b == {XLEN{1'b0}});
    assign w_q_fix      = (w_div_signed & (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -r_quo : r_quo;
    assign w_r_fix      = (w_div_signed & r_a[XLEN-1]) ? -r_rem : r_rem;
    assign w_div_result = r_op[1] ? (w_div_zero ? r_a : w_r_fix)
                                  : (w_div_zero ? {XLEN{1'b1}} : w_q_fix);
    assign w_md_result  = r_op[2] ? w_div_result : w_mul_result;

    // Gating with reset keeps o_stall low while reset is held mid-op
    assign w_start = i_rst_n & bus.i_valid & bus.i_md_en & ~bus.i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_md_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stall = 1'b1;
                    if (bus.i_md_op[2])        w_state_next = S_DIV;
                    else if (MUL_LATENCY == 1) w_state_next = S_DONE;
                    else                       w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (bus.i_flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == c_cnt_w'(c_mul_last)) w_state_next = S_DONE;
                end
            end
            S_DIV: begin
                if (bus.i_flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == c_cnt_w'(XLEN - 1)) w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_md_valid   = ~bus.i_flush;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_a   <= w_fwd_a;
                r_b   <= w_fwd_b;
                r_op  <= bus.i_md_op;
                r_cnt <= '0;
                r_quo <= w_a_mag;
                r_rem <= '0;
                r_dvs <= w_b_mag;
            end
        end else if (r_state == S_MUL) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_div_trial[XLEN]) begin
                r_rem <= w_div_shift[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end else begin
                r_rem <= w_div_trial[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end
        end
    end

    assign bus.o_result         = (r_state == S_DONE) ? w_md_result : w_alu_result;
    assign bus.o_result_valid   = (r_state == S_IDLE)
                                  ? (bus.i_valid & ~bus.i_md_en & ~bus.i_flush)
                                  : w_md_valid;
    assign bus.o_stall          = w_stall;
    assign bus.o_memory_data    = w_fwd_b;
    assign bus.o_alu_flags      = {w_alu_result[XLEN-1], (w_alu_result == {XLEN{1'b0}}), w_c, w_v};
    assign bus.o_pc_adder_result = (bus.i_pc_adder_src ? w_fwd_a : bus.i_pc) + bus.i_immext;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_stage_muldiv
// Brief    : Directed self-checking bench for exec_stage_muldiv.
// Revision : 1.0
// ============================================================================
module tb_exec_stage_muldiv;
    localparam int XLEN = 32;
    localparam int NUM_FWD = 2;
    localparam int MUL_LATENCY = 3;

    localparam logic [3:0] c_add = 4'd0, c_sub = 4'd1, c_slt = 4'd5, c_sltu = 4'd6;
    localparam logic [2:0] c_mul = 3'd0, c_mulh = 3'd1, c_mulhsu = 3'd2, c_mulhu = 3'd3;
    localparam logic [2:0] c_div = 3'd4, c_divu = 3'd5, c_rem = 3'd6, c_remu = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    exec_stage_muldiv_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) bus ();

    exec_stage_muldiv #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .MUL_LATENCY(MUL_LATENCY)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.i_valid = 0; bus.i_flush = 0; bus.i_rd1 = 0; bus.i_rd2 = 0;
        bus.i_immext = 0; bus.i_pc = 0; bus.i_fwd_data = 0;
        bus.i_fwd_sel_a = 0; bus.i_fwd_sel_b = 0; bus.i_alu_control = c_add;
        bus.i_alu_src_a = 0; bus.i_alu_src_b = 0; bus.i_pc_adder_src = 0;
        bus.i_md_en = 0; bus.i_md_op = 0;
    endtask

    // Issues one M op from the next cycle, counts stall cycles, checks the DONE cycle
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall,
                          input bit disturb);
        int n_stall;
        step();
        idle_in();
        bus.i_valid = 1; bus.i_md_en = 1; bus.i_md_op = op;
        bus.i_rd1 = a; bus.i_rd2 = b;
        #1;
        check({tag, " start_stall"}, 32'(bus.o_stall), 32'd1);
        n_stall = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (disturb) begin
                bus.i_rd1 = ~a; bus.i_rd2 = b + 3;
                bus.i_fwd_sel_a = 1; bus.i_fwd_sel_b = 2;
                bus.i_fwd_data = {$urandom(), $urandom()};
            end
            #1;
            if (!bus.o_stall) break;
            n_stall++;
        end
        check({tag, " stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        check({tag, " done_valid"}, 32'(bus.o_result_valid), 32'd1);
        check({tag, " result"}, bus.o_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_valid;
        idle_in();
        #1;
        check("rst stall", 32'(bus.o_stall), 32'd0);
        check("rst valid", 32'(bus.o_result_valid), 32'd0);
        check("rst result", bus.o_result, 32'd0);
        step();
        step();
        rst_n = 1;

        // Forwarding and ALU path (combinational, same cycle)
        step();
        bus.i_valid = 1; bus.i_rd1 = 1; bus.i_rd2 = 1;
        bus.i_fwd_data = {32'h55, 32'h11};
        bus.i_fwd_sel_a = 2; bus.i_fwd_sel_b = 1;
        bus.i_alu_src_b = 1; bus.i_immext = 4; bus.i_pc = 32'h100;
        bus.i_alu_control = c_add;
        #1;
        check("fwd src2 add", bus.o_result, 32'h59);
        check("alu valid", 32'(bus.o_result_valid), 32'd1);
        check("store data fwd1", bus.o_memory_data, 32'h11);
        check("pc adder pc", bus.o_pc_adder_result, 32'h104);
        bus.i_fwd_sel_a = 3;
        #1;
        check("fwd sel oor", bus.o_result, 32'h5);
        bus.i_fwd_sel_a = 2; bus.i_pc_adder_src = 1;
        #1;
        check("pc adder jalr", bus.o_pc_adder_result, 32'h59);
        bus.i_fwd_sel_a = 0; bus.i_fwd_sel_b = 0; bus.i_alu_src_b = 0;
        bus.i_alu_control = c_sub;
        #1;
        check("sub zero", bus.o_result, 32'h0);
        check("sub flags", 32'(bus.o_alu_flags), 32'h6);
        bus.i_rd1 = 32'hFFFFFFFF; bus.i_alu_control = c_slt;
        #1;
        check("slt", bus.o_result, 32'h1);
        bus.i_alu_control = c_sltu;
        #1;
        check("sltu", bus.o_result, 32'h0);
        bus.i_alu_src_a = 1; bus.i_alu_src_b = 1; bus.i_alu_control = c_add;
        #1;
        check("pc+imm", bus.o_result, 32'h104);
        bus.i_flush = 1;
        #1;
        check("flush alu valid", 32'(bus.o_result_valid), 32'd0);

        // Multiply
        run_md("mulhu", c_mulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 0);
        run_md("mul", c_mul, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 3, 0);
        run_md("mulh", c_mulh, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0);
        run_md("mulhsu", c_mulhsu, 32'd2, 32'hFFFFFFFF, 32'h1, 3, 0);

        // Divide
        run_md("div", c_div, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        run_md("rem", c_rem, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_md("divu", c_divu, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, 0);
        run_md("divu0", c_divu, 32'd9, 32'd0, 32'hFFFFFFFF, 33, 0);
        run_md("remu0", c_remu, 32'd9, 32'd0, 32'd9, 33, 0);
        run_md("div ovf", c_div, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);
        run_md("rem ovf", c_rem, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33, 0);
        run_md("divu hold", c_divu, 32'd100, 32'd7, 32'd14, 33, 1);

        // Flush mid-divide
        step();
        idle_in();
        bus.i_valid = 1; bus.i_md_en = 1; bus.i_md_op = c_div;
        bus.i_rd1 = 32'd1000; bus.i_rd2 = 32'd3;
        #1;
        check("flush start_stall", 32'(bus.o_stall), 32'd1);
        repeat (10) step();
        check("flush pre stall", 32'(bus.o_stall), 32'd1);
        bus.i_flush = 1;
        #1;
        check("flush stall", 32'(bus.o_stall), 32'd0);
        check("flush valid", 32'(bus.o_result_valid), 32'd0);
        step();
        idle_in();
        bus.i_valid = 1; bus.i_rd1 = 2; bus.i_rd2 = 3;
        #1;
        check("post flush idle valid", 32'(bus.o_result_valid), 32'd1);
        check("post flush idle result", bus.o_result, 32'd5);
        check("post flush stall", 32'(bus.o_stall), 32'd0);

        // Async reset mid-multiply
        step();
        idle_in();
        bus.i_valid = 1; bus.i_md_en = 1; bus.i_md_op = c_mul;
        bus.i_rd1 = 3; bus.i_rd2 = 4;
        step();
        check("rst mid stall before", 32'(bus.o_stall), 32'd1);
        rst_n = 0;
        #1;
        check("rst mid stall", 32'(bus.o_stall), 32'd0);
        check("rst mid valid", 32'(bus.o_result_valid), 32'd0);
        step();
        rst_n = 1;
        idle_in();
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.o_result_valid || bus.o_stall) n_valid++;
        end
        check("rst no result", 32'(n_valid), 32'd0);

        // Back-to-back multiplies
        run_md("b2b first", c_mul, 32'd6, 32'd7, 32'd42, 3, 0);
        run_md("b2b second", c_mul, 32'd5, 32'd5, 32'd25, 3, 0);
        step();
        idle_in();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
